xor_nn_ctrl: RTL and testbench
==============================

XOR_NN_CTRL -- requirements
Module: xor_nn_ctrl

Interface
REQ-001 SHALL have parameter BITS_PER_WORD, default 8, the signed weight word width.
REQ-002 SHALL have parameter INPUT_VECTOR_SIZE, default 2, the input bits per inference.
REQ-003 SHALL have parameter HIDDEN_LAYER_SIZE, default 2, the hidden neuron count.
REQ-004 SHALL have parameter OUTPUT_VECTOR_SIZE, default 1, the output bits.
REQ-005 SHALL have parameter BIAS_SIZE, default 1, the bias terms per layer.
REQ-006 SHALL have parameter NN_LATENCY, default 2, the cycles from nn_in_en to valid nn_out_data.
REQ-007 SHALL have parameters CLOG2_MAX_WEIGHTS_N and CLOG2_MAX_WEIGHTS_M, both default 2, the weight address widths.
REQ-008 SHALL have one clock and an asynchronous active-low reset, with ports as listed here.
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- wload_start  in  1  pulse: begin or restart a weight load
- w_valid  in  1  host weight word valid
- w_ready  out  1  controller accepts weight word
- w_data  in  BITS_PER_WORD  signed weight word
- req_valid  in  1  inference request valid
- req_ready  out  1  controller accepts request
- req_data  in  INPUT_VECTOR_SIZE  input vector
- rsp_valid  out  1  result valid
- rsp_ready  in  1  host accepts result
- rsp_data  out  OUTPUT_VECTOR_SIZE  result vector
- loaded  out  1  a complete weight set has been written
- nn_weights_en  out  1  datapath weight write strobe
- nn_weights_layer_address  out  1  0 = layer 1, 1 = layer 2
- nn_weights_n_address  out  CLOG2_MAX_WEIGHTS_N  row index
- nn_weights_m_address  out  CLOG2_MAX_WEIGHTS_M  column index
- nn_weights_data  out  BITS_PER_WORD  weight word
- nn_in_en  out  1  datapath input strobe
- nn_in_data  out  INPUT_VECTOR_SIZE  datapath input
- nn_out_data  in  OUTPUT_VECTOR_SIZE  datapath result

Function
REQ-009 SHALL implement states UNLOADED, LOAD, READY, ISSUE, WAIT and RESPOND.
REQ-010 In UNLOADED and READY, wload_start SHALL move the FSM to LOAD, clear the weight counter and deassert loaded.
REQ-011 In LOAD, w_ready SHALL be 1, and each w_valid&&w_ready cycle SHALL drive nn_weights_en=1 with the word and its address, all registered, one cycle later.
REQ-012 Load order SHALL be layer 0 with n=0..INPUT_VECTOR_SIZE+BIAS_SIZE-1 outer and m=0..HIDDEN_LAYER_SIZE-1 inner, then layer 1 with n=0..HIDDEN_LAYER_SIZE+BIAS_SIZE-1 outer and m=0..OUTPUT_VECTOR_SIZE-1 inner; this is 9 words at default parameters.
REQ-013 Accepting the last word SHALL move LOAD to READY and set loaded the following cycle.
REQ-014 wload_start asserted during LOAD SHALL restart the counter at word 0 and take priority over a simultaneous w_valid.
REQ-015 req_ready SHALL equal (state==READY && loaded && !wload_start).
REQ-016 A req_valid&&req_ready handshake SHALL latch req_data and enter ISSUE.
REQ-017 ISSUE SHALL last exactly one cycle, with nn_in_en=1 and nn_in_data equal to the latched vector, then enter WAIT.
REQ-018 WAIT SHALL count NN_LATENCY cycles, capture nn_out_data into rsp_data on the last cycle, then enter RESPOND.
REQ-019 RESPOND SHALL hold rsp_valid=1 and a stable rsp_data until rsp_ready, then return to READY; rsp_valid&&rsp_ready SHALL NOT coincide with a new req handshake in the same cycle.
REQ-020 wload_start SHALL be ignored in ISSUE, WAIT and RESPOND.
REQ-021 nn_weights_en and nn_in_en SHALL never both be 1 in the same cycle.

Reset
REQ-022 reset_n=0 SHALL asynchronously force state UNLOADED and set w_ready, req_ready, rsp_valid, loaded, nn_weights_en and nn_in_en to 0, with all counters, addresses, data outputs and rsp_data at 0.
REQ-023 Reset asserted mid-load or mid-inference SHALL abandon the operation, leaving loaded at 0 until a full reload completes.

Configuration
REQ-024 With XOR_NN_CTRL_PERF_EN defined, the module SHALL add output perf_count (16 bits), which increments on each rsp handshake, saturates at 16'hFFFF and resets to 0.
REQ-025 Without XOR_NN_CTRL_PERF_EN, the perf_count port and its logic SHALL be absent.

Verification
REQ-026 Reset, then 9 words (-1,1,1, 0,-1,1, 0,1,-2) -> nine nn_weights_en pulses with addresses (0,0,0)...(1,2,0) in order; loaded=1 after the ninth.
REQ-027 With weights loaded, req_data=2'b01 -> nn_in_en is 1 for exactly one cycle; rsp_valid rises NN_LATENCY+1 cycles after the handshake, with rsp_data equal to the model nn_out_data.
REQ-028 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stay stable and req_ready stays 0 throughout.
REQ-029 wload_start after word 4 of a load -> the next accepted word is written to address (0,0,0), and loaded asserts only after 9 further words.
REQ-030 reset_n driven low during WAIT -> all outputs are 0 immediately, loaded=0, and req_ready stays 0 until a reload completes.
REQ-031 XOR_NN_CTRL_PERF_EN defined, 3 inferences -> perf_count=3.

Source files
------------

// File: rtl/xor_nn_ctrl.sv
// -----------------------------------------------------------------------------
// xor_nn_ctrl
//
// Control front-end for a small two-layer neural-network datapath. It streams
// a host-supplied weight set into the datapath weight memory, then serves
// inference requests one at a time: it issues the input vector, waits the
// fixed datapath latency, captures the result and holds it for the host.
//
// Configuration macro:
//   XOR_NN_CTRL_PERF_EN - when defined, adds perf_count, a saturating 16-bit
//                         count of completed response handshakes.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   wload_start                     begin/restart a weight load
//   w_valid / w_ready / w_data      host weight word stream
//   req_valid / req_ready / req_data  inference request
//   rsp_valid / rsp_ready / rsp_data  inference result
//   loaded                          a complete weight set is in the datapath
//   nn_weights_en, nn_weights_layer_address, nn_weights_n_address,
//   nn_weights_m_address, nn_weights_data   datapath weight write port
//   nn_in_en, nn_in_data            datapath input strobe and vector
//   nn_out_data                     datapath result
// -----------------------------------------------------------------------------
module xor_nn_ctrl #(
  parameter int BITS_PER_WORD       = 8,
  parameter int INPUT_VECTOR_SIZE   = 2,
  parameter int HIDDEN_LAYER_SIZE   = 2,
  parameter int OUTPUT_VECTOR_SIZE  = 1,
  parameter int BIAS_SIZE           = 1,
  parameter int NN_LATENCY          = 2,
  parameter int CLOG2_MAX_WEIGHTS_N = 2,
  parameter int CLOG2_MAX_WEIGHTS_M = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           wload_start,
  input  logic                           w_valid,
  output logic                           w_ready,
  input  logic [BITS_PER_WORD-1:0]       w_data,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [INPUT_VECTOR_SIZE-1:0]   req_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [OUTPUT_VECTOR_SIZE-1:0]  rsp_data,
  output logic                           loaded,
  output logic                           nn_weights_en,
  output logic                           nn_weights_layer_address,
  output logic [CLOG2_MAX_WEIGHTS_N-1:0] nn_weights_n_address,
  output logic [CLOG2_MAX_WEIGHTS_M-1:0] nn_weights_m_address,
  output logic [BITS_PER_WORD-1:0]       nn_weights_data,
  output logic                           nn_in_en,
  output logic [INPUT_VECTOR_SIZE-1:0]   nn_in_data,
  input  logic [OUTPUT_VECTOR_SIZE-1:0]  nn_out_data
`ifdef XOR_NN_CTRL_PERF_EN
  ,
  output logic [15:0]                    perf_count
`endif
);

  localparam int NW  = CLOG2_MAX_WEIGHTS_N;
  localparam int MW  = CLOG2_MAX_WEIGHTS_M;
  localparam int WCW = (NN_LATENCY > 1) ? $clog2(NN_LATENCY) : 1;

  // Last row/column index of each layer's weight matrix (bias rows included).
  localparam logic [NW-1:0]  L0_N_LAST = NW'(INPUT_VECTOR_SIZE + BIAS_SIZE - 1);
  localparam logic [MW-1:0]  L0_M_LAST = MW'(HIDDEN_LAYER_SIZE - 1);
  localparam logic [NW-1:0]  L1_N_LAST = NW'(HIDDEN_LAYER_SIZE + BIAS_SIZE - 1);
  localparam logic [MW-1:0]  L1_M_LAST = MW'(OUTPUT_VECTOR_SIZE - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(NN_LATENCY - 1);

  typedef enum logic [2:0] {
    UNLOADED, LOAD, READY, ISSUE, WAIT, RESPOND
  } state_e;

  state_e                        state_q;
  logic                          layer_q, layer_d;
  logic [NW-1:0]                 n_q, n_d, n_last;
  logic [MW-1:0]                 m_q, m_d, m_last;
  logic                          last_word;
  logic [WCW-1:0]                wait_q;

  logic                          w_ready_q;
  logic                          loaded_q;
  logic                          rsp_valid_q;
  logic [OUTPUT_VECTOR_SIZE-1:0] rsp_data_q;
  logic                          wen_q;
  logic                          wl_q;
  logic [NW-1:0]                 wn_q;
  logic [MW-1:0]                 wm_q;
  logic [BITS_PER_WORD-1:0]      wdata_q;
  logic                          in_en_q;
  logic [INPUT_VECTOR_SIZE-1:0]  in_data_q;

  logic                          w_accept;
  logic                          req_hs;

  // A restart request wins over a word presented in the same cycle.
  assign w_accept  = w_ready_q && w_valid && !wload_start;
  assign req_ready = (state_q == READY) && loaded_q && !wload_start;
  assign req_hs    = req_valid && req_ready;

  // Weight address walk: m inner, n outer, layer 0 then layer 1.
  always_comb begin
    m_last    = layer_q ? L1_M_LAST : L0_M_LAST;
    n_last    = layer_q ? L1_N_LAST : L0_N_LAST;
    last_word = layer_q && (n_q == L1_N_LAST) && (m_q == L1_M_LAST);
    layer_d   = layer_q;
    n_d       = n_q;
    m_d       = m_q + MW'(1);
    if (m_q == m_last) begin
      m_d = '0;
      n_d = n_q + NW'(1);
      if (n_q == n_last) begin
        n_d     = '0;
        layer_d = 1'b1;
      end
    end
  end

`ifdef XOR_NN_CTRL_PERF_EN
  logic [15:0] perf_q;
  assign perf_count = perf_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= UNLOADED;
      layer_q     <= 1'b0;
      n_q         <= '0;
      m_q         <= '0;
      wait_q      <= '0;
      w_ready_q   <= 1'b0;
      loaded_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      wen_q       <= 1'b0;
      wl_q        <= 1'b0;
      wn_q        <= '0;
      wm_q        <= '0;
      wdata_q     <= '0;
      in_en_q     <= 1'b0;
      in_data_q   <= '0;
`ifdef XOR_NN_CTRL_PERF_EN
      perf_q      <= '0;
`endif
    end else begin
      // Both datapath strobes are single-cycle pulses.
      wen_q   <= 1'b0;
      in_en_q <= 1'b0;
      unique case (state_q)
        UNLOADED, READY: begin
          if (wload_start) begin
            state_q   <= LOAD;
            w_ready_q <= 1'b1;
            loaded_q  <= 1'b0;
            layer_q   <= 1'b0;
            n_q       <= '0;
            m_q       <= '0;
          end else if (req_hs) begin
            in_data_q <= req_data;
            in_en_q   <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        LOAD: begin
          if (wload_start) begin
            layer_q <= 1'b0;
            n_q     <= '0;
            m_q     <= '0;
          end else if (w_accept) begin
            wen_q   <= 1'b1;
            wl_q    <= layer_q;
            wn_q    <= n_q;
            wm_q    <= m_q;
            wdata_q <= w_data;
            layer_q <= layer_d;
            n_q     <= n_d;
            m_q     <= m_d;
            if (last_word) begin
              state_q   <= READY;
              w_ready_q <= 1'b0;
              loaded_q  <= 1'b1;
              layer_q   <= 1'b0;
              n_q       <= '0;
              m_q       <= '0;
            end
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          wait_q  <= '0;
        end
        WAIT: begin
          // The datapath result is valid during the last wait cycle.
          if (wait_q == WAIT_LAST) begin
            rsp_data_q  <= nn_out_data;
            rsp_valid_q <= 1'b1;
            state_q     <= RESPOND;
          end else begin
            wait_q <= wait_q + WCW'(1);
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= READY;
`ifdef XOR_NN_CTRL_PERF_EN
            if (perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
`endif
          end
        end
        default: state_q <= UNLOADED;
      endcase
    end
  end

  assign w_ready                  = w_ready_q;
  assign loaded                   = loaded_q;
  assign rsp_valid                = rsp_valid_q;
  assign rsp_data                 = rsp_data_q;
  assign nn_weights_en            = wen_q;
  assign nn_weights_layer_address = wl_q;
  assign nn_weights_n_address     = wn_q;
  assign nn_weights_m_address     = wm_q;
  assign nn_weights_data          = wdata_q;
  assign nn_in_en                 = in_en_q;
  assign nn_in_data               = in_data_q;

endmodule

// File: tb/tb_xor_nn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_xor_nn_ctrl
//
// Directed bench for xor_nn_ctrl. A datapath stub answers each nn_in_en with
// the XOR of the input bits, valid only in the cycle NN_LATENCY-1 after the
// strobe is seen (the complement otherwise). A transaction-level model checks
// every output on each falling edge; directed steps add literal expectations.
// -----------------------------------------------------------------------------
module tb_xor_nn_ctrl;
  localparam int BW = 8, IW = 2, HW = 2, OW = 1, BS = 1, LAT = 2, CN = 2, CM = 2;
  localparam int L0_WORDS = (IW + BS) * HW;
  localparam int TOTAL    = L0_WORDS + (HW + BS) * OW;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          wload_start = 1'b0, w_valid = 1'b0, req_valid = 1'b0, rsp_ready = 1'b0;
  logic [BW-1:0] w_data = '0;
  logic [IW-1:0] req_data = '0;
  logic          w_ready, req_ready, rsp_valid, loaded;
  logic [OW-1:0] rsp_data, nn_out_data;
  logic          nn_weights_en, nn_weights_layer_address, nn_in_en;
  logic [CN-1:0] nn_weights_n_address;
  logic [CM-1:0] nn_weights_m_address;
  logic [BW-1:0] nn_weights_data;
  logic [IW-1:0] nn_in_data;
`ifdef XOR_NN_CTRL_PERF_EN
  logic [15:0]   perf_count;
`endif

  always #5 clk = ~clk;

  xor_nn_ctrl #(
    .BITS_PER_WORD(BW), .INPUT_VECTOR_SIZE(IW), .HIDDEN_LAYER_SIZE(HW),
    .OUTPUT_VECTOR_SIZE(OW), .BIAS_SIZE(BS), .NN_LATENCY(LAT),
    .CLOG2_MAX_WEIGHTS_N(CN), .CLOG2_MAX_WEIGHTS_M(CM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wload_start(wload_start),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .loaded(loaded), .nn_weights_en(nn_weights_en),
    .nn_weights_layer_address(nn_weights_layer_address),
    .nn_weights_n_address(nn_weights_n_address),
    .nn_weights_m_address(nn_weights_m_address),
    .nn_weights_data(nn_weights_data), .nn_in_en(nn_in_en),
    .nn_in_data(nn_in_data), .nn_out_data(nn_out_data)
`ifdef XOR_NN_CTRL_PERF_EN
    , .perf_count(perf_count)
`endif
  );

  // Datapath stub: result valid only in the cycle the controller must capture.
  logic [1:0] dp_v = '0;
  logic       dp_res = 1'b0;
  always @(posedge clk) begin
    dp_v <= {dp_v[0], nn_in_en};
    if (nn_in_en) dp_res <= ^nn_in_data;
  end
  assign nn_out_data = dp_v[LAT-1] ? dp_res : ~dp_res;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Hand-computed load order for the nine default-size weights.
  int lay_t[9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
  int n_t[9]   = '{0, 0, 1, 1, 2, 2, 0, 1, 2};
  int m_t[9]   = '{0, 1, 0, 1, 0, 1, 0, 0, 0};
  int d_t[9]   = '{-1, 1, 1, 0, -1, 1, 0, 1, -2};

  typedef struct { int l; int n; int m; int d; } wr_t;
  wr_t cap[$];
  int  in_cnt = 0;

  // Transaction-level model state.
  bit            m_loading, m_loaded, m_busy, m_wen;
  int            m_widx, m_hs, m_wl, m_wn, m_wm, m_wd, m_perf;
  logic [IW-1:0] m_vec;

  always @(negedge clk) begin
    bit e_rq, e_rv;
    int w_act;
    if (!reset_n) begin
      m_loading = 0; m_loaded = 0; m_busy = 0; m_wen = 0;
      m_widx = 0; m_hs = 0; m_perf = 0; m_vec = '0;
    end
    e_rq  = !m_loading && m_loaded && !m_busy && !wload_start;
    e_rv  = m_busy && (m_hs >= LAT + 1);
    w_act = int'($signed(nn_weights_data));
    chk("w_ready", w_ready, m_loading);
    chk("req_ready", req_ready, e_rq);
    chk("loaded", loaded, m_loaded);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("nn_in_en", nn_in_en, m_busy && (m_hs == 0));
    chk("nn_weights_en", nn_weights_en, m_wen);
    chk("en_exclusive", nn_weights_en & nn_in_en, 0);
    if (m_wen) begin
      chk("w_layer", nn_weights_layer_address, m_wl);
      chk("w_n", nn_weights_n_address, m_wn);
      chk("w_m", nn_weights_m_address, m_wm);
      chk("w_data", w_act, m_wd);
    end
    if (nn_weights_en)
      cap.push_back('{int'(nn_weights_layer_address), int'(nn_weights_n_address),
                      int'(nn_weights_m_address), w_act});
    if (nn_in_en) begin
      in_cnt++;
      chk("nn_in_data", nn_in_data, m_vec);
    end
    if (e_rv) chk("rsp_data", rsp_data, ^m_vec);
`ifdef XOR_NN_CTRL_PERF_EN
    chk("perf_count", perf_count, m_perf);
`endif
    if (reset_n) begin
      m_wen = 0;
      if (wload_start && !m_busy) begin
        m_loading = 1; m_widx = 0; m_loaded = 0;
      end else if (m_loading && w_valid) begin
        m_wen = 1;
        m_wd  = int'($signed(w_data));
        if (m_widx < L0_WORDS) begin
          m_wl = 0; m_wn = m_widx / HW; m_wm = m_widx % HW;
        end else begin
          m_wl = 1; m_wn = (m_widx - L0_WORDS) / OW; m_wm = (m_widx - L0_WORDS) % OW;
        end
        m_widx++;
        if (m_widx == TOTAL) begin m_loading = 0; m_loaded = 1; end
      end
      if (e_rq && req_valid) begin
        m_busy = 1; m_hs = 0; m_vec = req_data;
      end else if (e_rv && rsp_ready) begin
        m_busy = 0;
        if (m_perf < 65535) m_perf++;
      end else if (m_busy) begin
        m_hs++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_wload();
    wload_start = 1'b1; tick(); wload_start = 1'b0;
  endtask

  task automatic send_word(input int d);
    int n = 0;
    w_valid = 1'b1; w_data = BW'(d);
    while (!w_ready && n < 50) begin tick(); n++; end
    if (!w_ready) chk("w_ready_timeout", w_ready, 1);
    tick(); w_valid = 1'b0;
  endtask

  task automatic check_cap();
    chk("lit_wr_count", cap.size(), 9);
    for (int i = 0; i < 9 && i < cap.size(); i++) begin
      chk("lit_wr_layer", cap[i].l, lay_t[i]);
      chk("lit_wr_n", cap[i].n, n_t[i]);
      chk("lit_wr_m", cap[i].m, m_t[i]);
      chk("lit_wr_data", cap[i].d, d_t[i]);
    end
  endtask

  task automatic load_all();
    pulse_wload();
    cap.delete();
    for (int i = 0; i < 9; i++) begin
      send_word(d_t[i]);
      if (i == 3) tick();
    end
    chk("lit_loaded_after_9", loaded, 1);
    tick();
    check_cap();
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_w_ready"}, w_ready, 0);
    chk({nm, "_req_ready"}, req_ready, 0);
    chk({nm, "_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_loaded"}, loaded, 0);
    chk({nm, "_nn_weights_en"}, nn_weights_en, 0);
    chk({nm, "_nn_in_en"}, nn_in_en, 0);
    chk({nm, "_rsp_data"}, rsp_data, 0);
    chk({nm, "_nn_in_data"}, nn_in_data, 0);
    chk({nm, "_w_addr"}, {nn_weights_layer_address, nn_weights_n_address, nn_weights_m_address}, 0);
    chk({nm, "_w_data"}, nn_weights_data, 0);
  endtask

  task automatic do_req(input logic [IW-1:0] vec, input int hold, input bit wl, input logic exp_bit);
    int n = 0;
    int lat;
    req_valid = 1'b1; req_data = vec;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (!req_ready) chk("req_ready_timeout", req_ready, 1);
    tick(); req_valid = 1'b0; req_data = ~vec;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      wload_start = wl && (lat < 2);
      tick(); lat++;
    end
    wload_start = 1'b0;
    chk("lit_rsp_valid", rsp_valid, 1);
    chk("lit_rsp_data", rsp_data, exp_bit);
    chk("lit_rsp_latency", lat, 3);
    repeat (hold) tick();
    chk("lit_rsp_data_held", rsp_data, exp_bit);
    chk("lit_req_ready_held", req_ready, 0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    all_zero("lit_rst");
    reset_n = 1'b1; tick();
    chk("lit_unloaded_req_ready", req_ready, 0);

    // Full load, then four inferences.
    load_all();
    in_cnt = 0;
    do_req(2'b01, 0, 1'b0, 1'b1);
    chk("lit_in_pulses", in_cnt, 1);
    do_req(2'b11, 5, 1'b1, 1'b0);
    do_req(2'b10, 0, 1'b0, 1'b1);
    do_req(2'b00, 1, 1'b0, 1'b0);

    // Reload from READY with a request present, then restart mid-load.
    wload_start = 1'b1; req_valid = 1'b1; req_data = 2'b01;
    tick();
    wload_start = 1'b0; req_valid = 1'b0;
    chk("lit_loaded_cleared", loaded, 0);
    chk("lit_w_ready_load", w_ready, 1);
    for (int i = 0; i < 4; i++) send_word(7);
    wload_start = 1'b1; w_valid = 1'b1; w_data = 8'd55;
    tick();
    wload_start = 1'b0; w_valid = 1'b0;
    cap.delete();
    for (int i = 0; i < 8; i++) send_word(d_t[i]);
    chk("lit_loaded_after_8", loaded, 0);
    send_word(d_t[8]);
    chk("lit_loaded_restart", loaded, 1);
    tick();
    check_cap();

    // Reset while the inference is waiting on the datapath.
    req_valid = 1'b1; req_data = 2'b10;
    begin
      int n = 0;
      while (!req_ready && n < 50) begin tick(); n++; end
    end
    tick(); req_valid = 1'b0;
    tick();
    reset_n = 1'b0; #1;
    all_zero("lit_wait_rst");
    tick();
    reset_n = 1'b1;
    req_valid = 1'b1; req_data = 2'b01;
    repeat (5) tick();
    chk("lit_req_ready_unloaded", req_ready, 0);
    req_valid = 1'b0;

    load_all();
    do_req(2'b01, 0, 1'b0, 1'b1);
    do_req(2'b10, 2, 1'b0, 1'b1);
    do_req(2'b11, 0, 1'b0, 1'b0);
`ifdef XOR_NN_CTRL_PERF_EN
    chk("lit_perf_count", perf_count, 3);
`endif
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
